// File: rtl/button_conditioner_pkg.sv
// Shared FSM state type, state width and default timing constants for button_conditioner.
package button_conditioner_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } btn_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES   = 1000000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 100000000;

    // Bits needed to hold the larger of two cycle counts without wrapping
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: 2-flop synchronizer, IDLE/DB_PRESS/HELD/DB_RELEASE debounce FSM and
// saturating counter. press_qualify is high in the cycle the FSM commits to HELD.
module btn_debounce_fsm
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEFAULT_DEBOUNCE_CYCLES, 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_qualify,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic             btn_sync_s;
    btn_state_e       state_r;
    btn_state_e       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             qualify_s;
    logic             level_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Two-flop synchronizer for the raw asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn_raw};
        end
    end

    assign btn_sync_s = sync_r[1];

    // State, debounce counter and registered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            level_r <= (next_state_s == ST_HELD) || (next_state_s == ST_DB_RELEASE);
        end
    end

    // Next state; the counter only advances on consecutive cycles at the new level
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = CNT_ZERO;
        qualify_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (btn_sync_s) begin
                    next_state_s = ST_DB_PRESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DB_PRESS: begin
                if (!btn_sync_s) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r >= DB_LAST) begin
                    next_state_s = ST_HELD;
                    qualify_s    = 1'b1;
                end else begin
                    cnt_next_s = sat_inc(cnt_r);
                end
            end
            ST_HELD: begin
                if (!btn_sync_s) begin
                    next_state_s = ST_DB_RELEASE;
                end else begin
                    next_state_s = ST_HELD;
                end
            end
            ST_DB_RELEASE: begin
                if (btn_sync_s) begin
                    next_state_s = ST_HELD;
                end else if (cnt_r >= DB_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    cnt_next_s = sat_inc(cnt_r);
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign press_qualify = qualify_s;
    assign level         = level_r;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the SOUTH/EAST/NORTH buttons into one-cycle command pulses with NORTH priority.
// Optional long-press detection on NORTH is built when LONG_PRESS_EN is defined.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic       CLK_50M,
    input  logic       RESET_N,
    input  logic       BTN_SOUTH,
    input  logic       BTN_EAST,
    input  logic       BTN_NORTH,
    output logic       START_STOP_PULSE,
    output logic       LAP_PULSE,
    output logic       CLEAR_PULSE,
    output logic       LONG_PRESS_PULSE,
    output logic [2:0] BTN_LEVEL
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);

    logic south_q_s;
    logic east_q_s;
    logic north_q_s;
    logic south_level_s;
    logic east_level_s;
    logic north_level_s;
    logic start_stop_r;
    logic lap_r;
    logic clear_r;

    btn_debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_south (
        .clk(CLK_50M), .rst_n(RESET_N), .btn_raw(BTN_SOUTH),
        .press_qualify(south_q_s), .level(south_level_s)
    );

    btn_debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_east (
        .clk(CLK_50M), .rst_n(RESET_N), .btn_raw(BTN_EAST),
        .press_qualify(east_q_s), .level(east_level_s)
    );

    btn_debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_north (
        .clk(CLK_50M), .rst_n(RESET_N), .btn_raw(BTN_NORTH),
        .press_qualify(north_q_s), .level(north_level_s)
    );

    // Pulse registers; a NORTH press swallows a coincident SOUTH/EAST press
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            start_stop_r <= 1'b0;
            lap_r        <= 1'b0;
            clear_r      <= 1'b0;
        end else begin
            start_stop_r <= south_q_s & ~north_q_s;
            lap_r        <= east_q_s & ~north_q_s;
            clear_r      <= north_q_s;
        end
    end

    assign START_STOP_PULSE = start_stop_r;
    assign LAP_PULSE        = lap_r;
    assign CLEAR_PULSE      = clear_r;
    assign BTN_LEVEL        = {north_level_s, east_level_s, south_level_s};

`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LP_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(LONG_PRESS_CYCLES);

    logic [CNT_W-1:0] lp_cnt_r;
    logic             long_press_r;

    // Held-time counter; saturating at the threshold makes the pulse fire once per hold
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            lp_cnt_r     <= LP_ZERO;
            long_press_r <= 1'b0;
        end else if (north_level_s) begin
            if (lp_cnt_r != LP_MAX) begin
                lp_cnt_r <= lp_cnt_r + LP_ONE;
            end else begin
                lp_cnt_r <= lp_cnt_r;
            end
            long_press_r <= (lp_cnt_r == LP_LAST);
        end else begin
            lp_cnt_r     <= LP_ZERO;
            long_press_r <= 1'b0;
        end
    end

    assign LONG_PRESS_PULSE = long_press_r;
`else
    assign LONG_PRESS_PULSE = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=40):
// directed scenarios plus random button activity against a run-length reference model.
module tb_button_conditioner;

    localparam int DB = 8;
    localparam int LP = 40;

    logic       CLK_50M   = 1'b0;
    logic       RESET_N   = 1'b0;
    logic       BTN_SOUTH = 1'b0;
    logic       BTN_EAST  = 1'b0;
    logic       BTN_NORTH = 1'b0;
    logic       START_STOP_PULSE;
    logic       LAP_PULSE;
    logic       CLEAR_PULSE;
    logic       LONG_PRESS_PULSE;
    logic [2:0] BTN_LEVEL;

    button_conditioner #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)) dut (
        .CLK_50M(CLK_50M), .RESET_N(RESET_N),
        .BTN_SOUTH(BTN_SOUTH), .BTN_EAST(BTN_EAST), .BTN_NORTH(BTN_NORTH),
        .START_STOP_PULSE(START_STOP_PULSE), .LAP_PULSE(LAP_PULSE),
        .CLEAR_PULSE(CLEAR_PULSE), .LONG_PRESS_PULSE(LONG_PRESS_PULSE),
        .BTN_LEVEL(BTN_LEVEL)
    );

    always #10 CLK_50M = ~CLK_50M;

    int total = 0;
    int bad   = 0;

    // Reference model: 2-sample input delay, accepted level, run of samples at the other level
    bit d1[3];
    bit d2[3];
    bit acc[3];
    int run[3];
    int held;
    bit e_ss, e_lap, e_clr, e_lp;

    // Per-scenario tallies of observed output activity
    int cyc, ss_n, lap_n, clr_n, lp_n, ss_at, lap_at, clr_at, lp_at, lvl0_low, lvl0_hi_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            d1[b] = 1'b0; d2[b] = 1'b0; acc[b] = 1'b0; run[b] = 0;
        end
        held = 0;
        e_ss = 1'b0; e_lap = 1'b0; e_clr = 1'b0; e_lp = 1'b0;
    endtask

    task automatic model_edge(input bit [2:0] raw);
        bit pr[3];
        bit north_pre;
        bit in_b;
        north_pre = acc[2];
        for (int b = 0; b < 3; b++) begin
            in_b  = d2[b];
            d2[b] = d1[b];
            d1[b] = raw[b];
            pr[b] = 1'b0;
            if (in_b != acc[b]) begin
                run[b]++;
                if (run[b] == DB + 1) begin
                    acc[b] = in_b;
                    run[b] = 0;
                    pr[b]  = in_b;
                end
            end else begin
                run[b] = 0;
            end
        end
        if (north_pre) held++; else held = 0;
        e_clr = pr[2];
        e_ss  = pr[0] && !pr[2];
        e_lap = pr[1] && !pr[2];
`ifdef LONG_PRESS_EN
        e_lp = (held == LP);
`else
        e_lp = 1'b0;
`endif
    endtask

    task automatic clr_tally();
        cyc = 0; ss_n = 0; lap_n = 0; clr_n = 0; lp_n = 0;
        ss_at = -1; lap_at = -1; clr_at = -1; lp_at = -1; lvl0_low = 0; lvl0_hi_at = -1;
    endtask

    task automatic cycle();
        @(posedge CLK_50M);
        if (!RESET_N) model_reset();
        else model_edge({BTN_NORTH, BTN_EAST, BTN_SOUTH});
        @(negedge CLK_50M);
        cyc++;
        chk("start_stop", START_STOP_PULSE, e_ss);
        chk("lap", LAP_PULSE, e_lap);
        chk("clear", CLEAR_PULSE, e_clr);
        chk("long_press", LONG_PRESS_PULSE, e_lp);
        chk("level", BTN_LEVEL, {acc[2], acc[1], acc[0]});
        if (START_STOP_PULSE) begin ss_n++; ss_at = cyc; end
        if (LAP_PULSE) begin lap_n++; lap_at = cyc; end
        if (CLEAR_PULSE) begin clr_n++; clr_at = cyc; end
        if (LONG_PRESS_PULSE) begin lp_n++; lp_at = cyc; end
        if (BTN_LEVEL[0]) lvl0_hi_at = cyc; else lvl0_low++;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) cycle();
    endtask

    logic [2:0] rv;
    int         rem[3];

    initial begin
        model_reset();
        clr_tally();
        @(negedge CLK_50M);
        run_cycles(3);
        chk("reset_level", BTN_LEVEL, 0);
        RESET_N = 1'b1;
        run_cycles(5);

        // Clean SOUTH press held 50 cycles, then release
        clr_tally(); BTN_SOUTH = 1'b1; run_cycles(50);
        chk("s1_pulses", ss_n, 1);
        chk("s1_latency", ss_at, 11);
        clr_tally(); BTN_SOUTH = 1'b0; run_cycles(20);
        chk("s1_level_last_high", lvl0_hi_at, 10);
        chk("s1_no_release_pulse", ss_n, 0);

        // EAST bouncing every 3 cycles, then stable
        clr_tally();
        for (int i = 0; i < 30; i++) begin
            BTN_EAST = (((i / 3) % 2) == 0) ? 1'b1 : 1'b0;
            cycle();
        end
        chk("s2_bounce_quiet", lap_n, 0);
        clr_tally(); BTN_EAST = 1'b1; run_cycles(20);
        chk("s2_pulses", lap_n, 1);
        chk("s2_latency", lap_at, 11);
        BTN_EAST = 1'b0; run_cycles(15);

        // SOUTH and NORTH qualify together: clear wins
        clr_tally(); BTN_SOUTH = 1'b1; BTN_NORTH = 1'b1; run_cycles(20);
        chk("s3_clear", clr_n, 1);
        chk("s3_start_masked", ss_n, 0);
        chk("s3_clear_at", clr_at, 11);
        BTN_SOUTH = 1'b0; BTN_NORTH = 1'b0; run_cycles(15);

        // Release glitch of 3 cycles inside HELD
        clr_tally(); BTN_SOUTH = 1'b1; run_cycles(20);
        BTN_SOUTH = 1'b0; run_cycles(3);
        BTN_SOUTH = 1'b1; run_cycles(20);
        chk("s4_pulses", ss_n, 1);
        chk("s4_level_low_cycles", lvl0_low, 10);
        BTN_SOUTH = 1'b0; run_cycles(15);

        // NORTH held 100 cycles
        clr_tally(); BTN_NORTH = 1'b1; run_cycles(100);
        chk("s5_clear", clr_n, 1);
`ifdef LONG_PRESS_EN
        chk("s5_long_press", lp_n, 1);
        chk("s5_long_delay", lp_at - clr_at, 40);
`else
        chk("s5_long_press", lp_n, 0);
`endif
        BTN_NORTH = 1'b0; run_cycles(15);

        // Reset mid-DB_PRESS with buttons held
        BTN_EAST = 1'b1; run_cycles(15);
        BTN_SOUTH = 1'b1; run_cycles(5);
        RESET_N = 1'b0;
        #1;
        chk("s6_async_level", BTN_LEVEL, 0);
        chk("s6_async_pulses", {START_STOP_PULSE, LAP_PULSE, CLEAR_PULSE, LONG_PRESS_PULSE}, 0);
        run_cycles(2);
        RESET_N = 1'b1;
        clr_tally(); run_cycles(15);
        chk("s6_pulses", ss_n, 1);
        chk("s6_latency", ss_at, 11);
        chk("s6_lap_latency", lap_at, 11);
        BTN_SOUTH = 1'b0; BTN_EAST = 1'b0; run_cycles(15);

        // Random activity on all three buttons, with one reset in the middle
        rv = 3'b000;
        for (int b = 0; b < 3; b++) rem[b] = 0;
        for (int i = 0; i < 900; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    rv[b]  = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
                    rem[b] = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 70)
                                                         : $urandom_range(1, 14);
                end
                rem[b]--;
            end
            BTN_SOUTH = rv[0]; BTN_EAST = rv[1]; BTN_NORTH = rv[2];
            RESET_N = (i >= 500 && i < 502) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
- REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles to accept a level change (20 ms at 50 MHz).
- REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 100000000, hold time in cycles for a long press (2 s).
- REQ-003 SHALL have port CLK_50M, input, 1 bit, the single clock domain.
- REQ-004 SHALL have port RESET_N, input, 1 bit, asynchronous active-low reset.
- REQ-005 SHALL have port BTN_SOUTH, input, 1 bit, raw asynchronous start/stop button, active-high.
- REQ-006 SHALL have port BTN_EAST, input, 1 bit, raw asynchronous lap button, active-high.
- REQ-007 SHALL have port BTN_NORTH, input, 1 bit, raw asynchronous reset button, active-high.
- REQ-008 SHALL have port START_STOP_PULSE, output, 1 bit, one-cycle pulse per accepted SOUTH press.
- REQ-009 SHALL have port LAP_PULSE, output, 1 bit, one-cycle pulse per accepted EAST press.
- REQ-010 SHALL have port CLEAR_PULSE, output, 1 bit, one-cycle pulse per accepted NORTH press.
- REQ-011 SHALL have port LONG_PRESS_PULSE, output, 1 bit, one-cycle pulse when NORTH is held long.
- REQ-012 SHALL have port BTN_LEVEL, output, 3 bits, debounced levels {NORTH, EAST, SOUTH}.

Function
- REQ-013 SHALL pass each button through a 2-flop synchronizer before any other logic.
- REQ-014 SHALL run one FSM per button with states IDLE, DB_PRESS, HELD and DB_RELEASE.
- REQ-015 SHALL move an FSM from IDLE to DB_PRESS when the synchronized level goes high, with the counter cleared.
- REQ-016 SHALL, in DB_PRESS, return to IDLE on a low level; after DEBOUNCE_CYCLES consecutive high cycles it SHALL enter HELD.
- REQ-017 SHALL assert the button's pulse for exactly the one cycle following the transition into HELD.
- REQ-018 SHALL move from HELD to DB_RELEASE on a low level; DB_RELEASE SHALL return to HELD on a high level and enter IDLE after DEBOUNCE_CYCLES consecutive low cycles, with no pulse on release.
- REQ-019 SHALL report BTN_LEVEL bit = 1 in HELD and DB_RELEASE, and 0 otherwise.
- REQ-020 SHALL produce at most one pulse per press regardless of hold duration.
- REQ-021 SHALL, when CLEAR_PULSE is asserted, force START_STOP_PULSE and LAP_PULSE to 0 in that cycle; the suppressed presses are lost.
- REQ-022 SHALL allow START_STOP_PULSE and LAP_PULSE to assert in the same cycle.
- REQ-023 SHALL size counters to ceil(log2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)+1)) bits and saturate them, never wrap.
- REQ-024 SHALL have a worst-case latency from a clean press edge to the pulse of 2 + DEBOUNCE_CYCLES + 1 cycles.

Reset
- REQ-025 SHALL, on RESET_N low, asynchronously clear all pulses, BTN_LEVEL, synchronizers and counters, and put every FSM in IDLE.
- REQ-026 SHALL, when a button is held through reset release, require a full DB_PRESS qualification before pulsing.

Configuration
- REQ-027 SHALL, with macro LONG_PRESS_EN defined, pulse LONG_PRESS_PULSE once when the NORTH FSM has stayed in HELD/DB_RELEASE for LONG_PRESS_CYCLES cycles since entering HELD.
- REQ-028 SHALL not re-arm LONG_PRESS_PULSE until the NORTH FSM has returned to IDLE.
- REQ-029 SHALL, without LONG_PRESS_EN, tie LONG_PRESS_PULSE to 0 and implement no long-press counter.

Structure
- REQ-030 SHALL place the FSM state enum, the state width constant and the default cycle constants in a shared package, button_conditioner_pkg.
- REQ-031 SHALL implement the synchronizer, FSM and debounce counter as one sub-module, btn_debounce_fsm, instantiated three times.
- REQ-032 SHALL keep the long-press logic and the clear-priority masking in the top level.

Verification (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=40)
- REQ-033 SHALL cover a clean SOUTH press held 50 cycles: exactly one START_STOP_PULSE, 11 cycles after the edge; BTN_LEVEL[0]=1 until 10 cycles after release.
- REQ-034 SHALL cover an EAST press bouncing high/low every 3 cycles for 30 cycles then stable high: no pulse during bounce, one LAP_PULSE after 8 stable cycles.
- REQ-035 SHALL cover SOUTH and NORTH qualifying in the same cycle: CLEAR_PULSE=1 and START_STOP_PULSE=0.
- REQ-036 SHALL cover a release glitch (low 3 cycles inside HELD): no second pulse and BTN_LEVEL stays 1.
- REQ-037 SHALL cover NORTH held 100 cycles with LONG_PRESS_EN defined: one CLEAR_PULSE, then one LONG_PRESS_PULSE 40 cycles later; without the macro, LONG_PRESS_PULSE stays 0.
- REQ-038 SHALL cover RESET_N pulsed low mid-DB_PRESS with the button still held: outputs go 0 immediately, and a pulse appears 11 cycles after reset deassertion.
